// File: rtl/mem_arbiter.sv
// Byte-serialising arbiter that shares one 8-bit RAM port between instruction fetch and the MEM stage.
// MEM has fixed priority; once a transaction is accepted it runs to completion, unless IF aborts its own read.
module mem_arbiter #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h00030000)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   input  logic                  if_abort_i,
   input  logic                  mem_req_i,
   input  logic                  mem_we_i,
   input  logic [1:0]            mem_len_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [31:0]           mem_wdata_i,
   input  logic [7:0]            mem_din_i,
   input  logic                  io_buffer_full_i,
   output logic                  if_done_o,
   output logic [31:0]           if_data_o,
   output logic                  mem_done_o,
   output logic [31:0]           mem_data_o,
   output logic [ADDR_WIDTH-1:0] mem_a_o,
   output logic [7:0]            mem_dout_o,
   output logic                  mem_wr_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;    // 1 = MEM, 0 = IF
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [2:0]            len_q, len_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [31:0]           rbuf_q, rbuf_d;
   logic                  if_done_q, if_done_d;
   logic [31:0]           if_data_q, if_data_d;
   logic                  mem_done_q, mem_done_d;
   logic [31:0]           mem_data_q, mem_data_d;
   logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
   logic [7:0]            mem_dout_q, mem_dout_d;
   logic                  mem_wr_q, mem_wr_d;

   logic [2:0]            mem_n_s;
   logic [ADDR_WIDTH-1:0] wr_base_s, wr_addr_s, rd_addr_s;
   logic [31:0]           wr_data_s, rd_word_s;
   logic [2:0]            wr_idx_s;
   logic [7:0]            wr_byte_s;
   logic [1:0]            cap_idx_s;
   logic                  stall_s;

   // Byte count, the next store byte (on the accept edge it comes straight from the inputs) and the read word being assembled.
   always_comb begin
      case (mem_len_i)
         2'b00:   mem_n_s = 3'd1;
         2'b01:   mem_n_s = 3'd2;
         default: mem_n_s = 3'd4;
      endcase
      wr_base_s = (state_q == IDLE) ? mem_addr_i  : addr_q;
      wr_data_s = (state_q == IDLE) ? mem_wdata_i : wdata_q;
      wr_idx_s  = (state_q == IDLE) ? 3'd0        : cnt_q;
      wr_addr_s = wr_base_s + {{(ADDR_WIDTH-3){1'b0}}, wr_idx_s};
      wr_byte_s = wr_data_s[{wr_idx_s[1:0], 3'b000} +: 8];
      stall_s   = (wr_addr_s >= IO_BASE) && io_buffer_full_i;
      rd_addr_s = addr_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
      cap_idx_s = 2'(cnt_q - 3'd2);
      rd_word_s = rbuf_q;
      if (cnt_q >= 3'd2) begin
         rd_word_s[{cap_idx_s, 3'b000} +: 8] = mem_din_i;
      end else begin
         rd_word_s = rbuf_q;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      rbuf_d     = rbuf_q;
      if_done_d  = 1'b0;
      if_data_d  = if_data_q;
      mem_done_d = 1'b0;
      mem_data_d = mem_data_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_req_i) begin
               owner_d = 1'b1;
               addr_d  = mem_addr_i;
               wdata_d = mem_wdata_i;
               len_d   = mem_n_s;
               rbuf_d  = 32'd0;
               mem_a_d = mem_addr_i;
               if (mem_we_i) begin
                  state_d    = WRITE;
                  mem_dout_d = wr_byte_s;
                  mem_wr_d   = !stall_s;
                  cnt_d      = stall_s ? 3'd0 : 3'd1;
               end else begin
                  state_d = READ;
                  cnt_d   = 3'd1;
               end
            end else if (if_req_i && !if_abort_i) begin
               owner_d = 1'b0;
               addr_d  = if_addr_i;
               len_d   = 3'd4;
               rbuf_d  = 32'd0;
               mem_a_d = if_addr_i;
               state_d = READ;
               cnt_d   = 3'd1;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (!owner_q && if_abort_i) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
               rbuf_d  = 32'd0;
            end else begin
               if (cnt_q < len_q) begin
                  mem_a_d = rd_addr_s;
               end else begin
                  mem_a_d = mem_a_q;
               end
               rbuf_d = rd_word_s;
               if (cnt_q == len_q + 3'd1) begin
                  state_d = DONE;
                  cnt_d   = 3'd0;
                  if (owner_q) begin
                     mem_done_d = 1'b1;
                     mem_data_d = rd_word_s;
                  end else begin
                     if_done_d = 1'b1;
                     if_data_d = rd_word_s;
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         WRITE: begin
            if (cnt_q == len_q) begin
               mem_done_d = 1'b1;
               state_d    = DONE;
               cnt_d      = 3'd0;
            end else begin
               // A stalled I/O byte keeps its index so it is written exactly once.
               mem_a_d    = wr_addr_s;
               mem_dout_d = wr_byte_s;
               mem_wr_d   = !stall_s;
               cnt_d      = stall_s ? cnt_q : cnt_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         len_q      <= 3'd0;
         cnt_q      <= 3'd0;
         rbuf_q     <= 32'd0;
         if_done_q  <= 1'b0;
         if_data_q  <= 32'd0;
         mem_done_q <= 1'b0;
         mem_data_q <= 32'd0;
         mem_a_q    <= '0;
         mem_dout_q <= 8'd0;
         mem_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         rbuf_q     <= rbuf_d;
         if_done_q  <= if_done_d;
         if_data_q  <= if_data_d;
         mem_done_q <= mem_done_d;
         mem_data_q <= mem_data_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
      end
   end

   assign if_done_o  = if_done_q;
   assign if_data_o  = if_data_q;
   assign mem_done_o = mem_done_q;
   assign mem_data_o = mem_data_q;
   assign mem_a_o    = mem_a_q;
   assign mem_dout_o = mem_dout_q;
   assign mem_wr_o   = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a synchronous byte RAM model, expected reads and writes queued at stimulus time.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_abort, mem_req, mem_we, io_full;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [1:0]  mem_len;
   logic [7:0]  mem_din;
   logic        if_done_o, mem_done_o, mem_wr_o;
   logic [31:0] if_data_o, mem_data_o, mem_a_o;
   logic [7:0]  mem_dout_o;

   logic        pre_we;
   logic [17:0] pre_addr;
   logic [7:0]  pre_data;
   logic [7:0]  ram [0:(1<<18)-1];

   logic [31:0] if_q [$];
   logic [32:0] mem_q [$];   // bit 32 set = load whose data must be compared
   logic [39:0] wr_q [$];
   logic [32:0] mem_e;
   int          n_chk = 0;
   int          n_fail = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_abort_i(if_abort),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
      .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_din_i(mem_din),
      .io_buffer_full_i(io_full),
      .if_done_o(if_done_o), .if_data_o(if_data_o),
      .mem_done_o(mem_done_o), .mem_data_o(mem_data_o),
      .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: address sampled on the edge, data valid for the following cycle.
   always @(posedge clk) begin
      if (pre_we) ram[pre_addr] <= pre_data;
      else if (mem_wr_o) ram[mem_a_o[17:0]] <= mem_dout_o;
      mem_din <= ram[mem_a_o[17:0]];
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (if_done_o) begin
            if (if_q.size() == 0) check_eq("if_done_unexp", if_done_o, 1'b0);
            else check_eq("if_data", if_data_o, if_q.pop_front());
         end
         if (mem_done_o) begin
            if (mem_q.size() == 0) check_eq("mem_done_unexp", mem_done_o, 1'b0);
            else begin
               mem_e = mem_q.pop_front();
               if (mem_e[32]) check_eq("mem_data", mem_data_o, mem_e[31:0]);
            end
         end
         if (mem_wr_o) begin
            if (wr_q.size() == 0) check_eq("wr_unexp", mem_wr_o, 1'b0);
            else check_eq("wr_addr_byte", {mem_a_o, mem_dout_o}, wr_q.pop_front());
         end
      end
   end

   task automatic preload(input logic [17:0] a, input logic [7:0] d);
      pre_addr = a; pre_data = d; pre_we = 1'b1;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic run_if(input logic [31:0] addr, input int exp_lat);
      int lat;
      logic [31:0] ea;
      lat = -1;
      if_addr = addr; if_req = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         ea = addr + 32'(c) - 32'd1;
         if (c <= 4) check_eq("if_addr_seq", mem_a_o, ea);
         if (if_done_o) begin lat = c - 1; break; end
      end
      if_req = 1'b0;
      check_eq("if_latency", lat, exp_lat);
      @(negedge clk);
      check_eq("if_done_pulse", if_done_o, 1'b0);
   endtask

   task automatic run_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wd, input int exp_lat);
      int lat;
      lat = -1;
      mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd; mem_req = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (mem_done_o) begin lat = c - 1; break; end
      end
      mem_req = 1'b0;
      check_eq("mem_latency", lat, exp_lat);
      @(negedge clk);
      check_eq("mem_done_pulse", mem_done_o, 1'b0);
   endtask

   initial begin
      int mlat, ilat, seen;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int mlat, ilat, seen;
      rst = 1'b0; if_req = 1'b0; if_abort = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      io_full = 1'b0; if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
      mem_len = 2'b00; pre_we = 1'b0; pre_addr = 18'd0; pre_data = 8'd0;
      @(negedge clk);
      preload(18'h00100, 8'h13); preload(18'h00101, 8'h05);
      preload(18'h00102, 8'h10); preload(18'h00103, 8'h00);
      preload(18'h00040, 8'h9C);
      preload(18'h00300, 8'h11); preload(18'h00301, 8'h22);
      preload(18'h00302, 8'h33); preload(18'h00303, 8'h44);
      preload(18'h3FFFE, 8'hA1); preload(18'h3FFFF, 8'hB2);
      preload(18'h00000, 8'hC3); preload(18'h00001, 8'hD4);
      check_eq("rst_if_done", if_done_o, 1'b0);
      check_eq("rst_if_data", if_data_o, 32'd0);
      check_eq("rst_mem_done", mem_done_o, 1'b0);
      check_eq("rst_mem_data", mem_data_o, 32'd0);
      check_eq("rst_mem_a", mem_a_o, 32'd0);
      check_eq("rst_mem_dout", mem_dout_o, 8'd0);
      check_eq("rst_mem_wr", mem_wr_o, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      if_q.push_back(32'h00100513);
      run_if(32'h00000100, 5);

      wr_q.push_back({32'h200, 8'hEF}); wr_q.push_back({32'h201, 8'hBE});
      wr_q.push_back({32'h202, 8'hAD}); wr_q.push_back({32'h203, 8'hDE});
      mem_q.push_back({1'b0, 32'd0});
      run_mem(1'b1, 2'b10, 32'h200, 32'hDEADBEEF, 4);
      check_eq("store_all_bytes", wr_q.size(), 0);

      mem_q.push_back({1'b1, 32'h0000DEAD});
      run_mem(1'b0, 2'b01, 32'h202, 32'd0, 3);
      mem_q.push_back({1'b1, 32'hDEADBEEF});
      run_mem(1'b0, 2'b11, 32'h200, 32'd0, 5);

      // Simultaneous requests: MEM first, IF accepted on the first IDLE edge after DONE.
      mem_q.push_back({1'b1, 32'h0000009C});
      if_q.push_back(32'h00100513);
      mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h40; mem_req = 1'b1;
      if_addr = 32'h100; if_req = 1'b1;
      mlat = -1; ilat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) check_eq("arb_a_mem", mem_a_o, 32'h40);
         if (c == 5) check_eq("arb_a_if", mem_a_o, 32'h100);
         if (mem_done_o && mlat < 0) begin mlat = c - 1; mem_req = 1'b0; end
         if (if_done_o) begin ilat = c - 1; break; end
      end
      if_req = 1'b0; mem_req = 1'b0;
      check_eq("arb_mem_lat", mlat, 2);
      check_eq("arb_if_lat", ilat, 9);
      @(negedge clk);

      // Abort sampled at E2, then a clean read of a different word.
      if_addr = 32'h100; if_req = 1'b1;
      @(negedge clk); @(negedge clk);
      if_abort = 1'b1;
      @(negedge clk);
      if_abort = 1'b0; if_req = 1'b0;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (if_done_o) seen++;
      end
      check_eq("abort_nodone", seen, 0);
      if_q.push_back(32'h44332211);
      run_if(32'h300, 5);

      // I/O store held off by a full UART buffer for three edges.
      wr_q.push_back({32'h00030000, 8'h41});
      mem_q.push_back({1'b0, 32'd0});
      io_full = 1'b1;
      mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h00030000; mem_wdata = 32'h00000041; mem_req = 1'b1;
      mlat = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c <= 3) check_eq("io_wr_stall", mem_wr_o, 1'b0);
         if (c == 3) io_full = 1'b0;
         if (mem_done_o) begin mlat = c - 1; break; end
      end
      mem_req = 1'b0; io_full = 1'b0;
      check_eq("io_latency", mlat, 4);
      check_eq("io_one_write", wr_q.size(), 0);
      @(negedge clk);

      if_q.push_back(32'hD4C3B2A1);
      run_if(32'hFFFFFFFE, 5);

      // Reset in the middle of a read.
      if_addr = 32'h300; if_req = 1'b1;
      @(negedge clk); @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_if_done", if_done_o, 1'b0);
      check_eq("midrst_if_data", if_data_o, 32'd0);
      check_eq("midrst_mem_data", mem_data_o, 32'd0);
      check_eq("midrst_mem_a", mem_a_o, 32'd0);
      check_eq("midrst_mem_wr", mem_wr_o, 1'b0);
      if_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      if_q.push_back(32'h44332211);
      run_if(32'h300, 5);

      repeat (3) @(negedge clk);
      check_eq("if_q_drained", if_q.size(), 0);
      check_eq("mem_q_drained", mem_q.size(), 0);
      check_eq("wr_q_drained", wr_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single byte-wide external RAM port between two requesters: the instruction-fetch stage (4-byte reads) and the memory stage (1/2/4-byte loads and stores).
- Sits between the pipeline stages and the top-level mem_a/mem_din/mem_dout/mem_wr pins.
- Owns all byte-serialisation, so requesters see a single word-level req/done handshake.
- Supports IF abort on branch redirect and stalls I/O writes while the UART buffer is full.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses.
- IO_BASE, 32'h00030000, addresses >= IO_BASE are I/O; writes there obey io_buffer_full_i.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk edge).
- if_req_i  in  1  IF requests a 4-byte read; held high until if_done_o or abort.
- if_addr_i  in  ADDR_WIDTH  IF byte address; stable while if_req_i is high.
- if_abort_i  in  1  cancels any pending or in-flight IF read.
- mem_req_i  in  1  MEM stage request; held until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_len_i  in  2  00 = 1 byte, 01 = 2 bytes, 10 or 11 = 4 bytes.
- mem_addr_i  in  ADDR_WIDTH  MEM byte address.
- mem_wdata_i  in  32  store data, little-endian (byte k = bits 8k+7:8k).
- mem_din_i  in  8  RAM read data; valid one cycle after the address is sampled by RAM.
- io_buffer_full_i  in  1  UART output buffer full.
- if_done_o  out  1  one-cycle pulse; if_data_o is valid.
- if_data_o  out  32  fetched word.
- mem_done_o  out  1  one-cycle pulse; load data valid or store complete.
- mem_data_o  out  32  load data, zero-extended.
- mem_a_o  out  ADDR_WIDTH  RAM address.
- mem_dout_o  out  8  RAM write byte.
- mem_wr_o  out  1  RAM write enable.

Behaviour:
- All outputs are registered.
- Reset (rst == 0 at an edge):
  - state = IDLE.
  - All outputs = 0.
  - Byte buffers and counters = 0.
  - Any in-flight transaction is discarded with no done pulse.
- States: IDLE, READ, WRITE, DONE.
- Owner register: IF or MEM; fixed at acceptance.
- IDLE arbitration:
  - If mem_req_i, accept MEM.
  - Else if if_req_i && !if_abort_i, accept IF.
  - MEM has fixed priority. There is no preemption once a transaction is accepted.
- Length N: 4 for IF; decoded from mem_len_i for MEM.
- Read, request accepted at edge E0:
  - At E0..E(N-1): mem_a_o <= addr + k for k = 0..N-1, and mem_wr_o <= 0.
  - At E2..E(N+1): capture mem_din_i into byte k-... in order, i.e. byte 0 is captured at E2.
  - At E(N+1): assemble the final word, pulse the owner's done_o and data output, then enter DONE.
  - Total: done is high in the cycle after E(N+1). Latency is N+1 edges after acceptance (IF: 5).
  - After the last issue, mem_a_o holds its final value.
- Write (MEM only), accepted at E0:
  - At Ek, for k = 0..N-1: mem_a_o <= addr + k, mem_dout_o <= byte k, mem_wr_o <= 1.
  - At E(N): mem_wr_o <= 0 and mem_done_o <= 1, then enter DONE. Latency is N edges.
- I/O stall: while writing a byte whose address is >= IO_BASE and io_buffer_full_i == 1:
  - Drive mem_wr_o <= 0 and do not advance the byte index.
  - Re-issue the same byte on the first edge where io_buffer_full_i == 0.
  - Each I/O byte is written exactly once.
- DONE state (one cycle):
  - Clear both done pulses.
  - No request is accepted on this edge, so a still-high req is never double-served.
  - Return to IDLE.
- Abort:
  - if_abort_i sampled high while the owner is IF in READ: go to IDLE at that edge, with no if_done_o. Captured bytes are discarded.
  - A stale in-flight RAM byte is ignored because a new read captures only from its own E2.
  - Abort during a MEM transaction has no effect.
  - Abort in IDLE blocks acceptance of IF on that edge only.
- Data holding:
  - if_data_o and mem_data_o hold their last value until the next done for the same requester.
  - For 1- and 2-byte loads, the upper bytes of mem_data_o are zero.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps at the top address).
- Simultaneous mem_req_i and if_req_i in IDLE: MEM is served first; IF is accepted at the first IDLE edge after DONE.

Test Plan:
- IF read at 0x100, RAM bytes 0x13, 0x05, 0x10, 0x00 -> mem_a_o = 0x100..0x103 on consecutive cycles; if_done_o pulses 5 edges after acceptance; if_data_o = 0x00100513; if_done_o is high for exactly 1 cycle.
- MEM store, len = 10, addr 0x200, wdata 0xDEADBEEF -> four cycles with mem_wr_o = 1 and (a, dout) = (0x200, EF), (0x201, BE), (0x202, AD), (0x203, DE); mem_done_o pulses at E4.
- mem_req_i (load, len = 00, addr 0x40, byte 0x9C) and if_req_i asserted together -> MEM is served first with mem_data_o = 0x0000009C; IF is accepted afterwards; no overlap on mem_a_o.
- IF read, if_abort_i pulsed at E2 -> no if_done_o; the next IF request to 0x300 returns the correct word with no corrupted byte.
- Store byte 0x41 to 0x30000 with io_buffer_full_i high for 3 cycles -> mem_wr_o stays 0 for those cycles; exactly one write of 0x41 follows; then mem_done_o.
- rst driven to 0 mid-read -> all outputs are 0 on the next edge; no done pulse; a new request after rst returns to 1 completes normally.
